dm_banked: RTL and testbench
============================

// Module: dm_banked
// PURPOSE
//  Parametrised single-port data memory for the MIPS core's MEM stage; successor of the flat 4K-word DM.
//  Byte-enable writes replace read-modify-write; loads return extracted and sign/zero-extended data.
//  Registered 1-cycle response with misalignment and out-of-range error flags.
//  Clear is a multi-cycle sweep FSM with a ready handshake, not a single-cycle array wipe.
// PARAMETERS
//  ADDR_W     12            word-address bits; DEPTH = 2**ADDR_W words of 32 bits
//  BASE_ADDR  32'h0000_0000 byte address of word 0; must be aligned to DEPTH*4
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  clr        in   1   synchronous active-high reset; restarts the clear sweep
//  req        in   1   access request; accepted when req & ready
//  we         in   1   1 = store, 0 = load
//  ctl        in   2   0 byte, 1 half, 2 word, 3 illegal
//  sext       in   1   loads: 1 = sign-extend, 0 = zero-extend (ignored for word)
//  addr       in   32  byte address
//  wd         in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  pc         in   32  PC of the issuing instruction, used by trace only
//  ready      out  1   1 = IDLE, request may be accepted this cycle
//  resp_valid out  1   1-cycle pulse, one cycle after each accepted request
//  rd         out  32  load result; 0 for stores and errored requests
//  err_mis    out  1   valid with resp_valid: misaligned address or ctl==3
//  err_range  out  1   valid with resp_valid: addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4)
// BEHAVIOUR
//  Reset (clr=1 at posedge): state<=CLEAR, clr_cnt<=0, ready=0, resp_valid=0, rd=0, err_*=0.
//   Requests present in the reset cycle are dropped without response.
//  CLEAR: each cycle with clr=0 writes mem[clr_cnt]<=0, clr_cnt++.
//   After writing DEPTH-1, state<=IDLE.
//   ready rises on the DEPTH-th posedge after clr falls.
//   clr re-asserted mid-sweep restarts from 0.
//  IDLE: ready=1. Accept at most one request per cycle; no back-pressure in IDLE.
//  Alignment: half needs addr[0]==0; word needs addr[1:0]==2'b00; ctl==3 is always err_mis.
//  Range: addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2] -> err_range. Both errors may set together.
//  Any error: no memory write; resp_valid=1, rd=0, flags set for that one cycle.
//  Store: byte enables from ctl/addr[1:0]; byte lane k gets wd[7:0], half lane h gets wd[15:0].
//   Write lands at the accept edge; response next cycle, rd=0.
//  Load: word index addr[ADDR_W+1:2]; lane selected by addr[1:0], then extended per sext.
//   Data appears on rd with resp_valid, exactly 1 cycle after accept.
//   rd and err_* hold their values until the next resp_valid or clr.
//  Store then load to the same word on consecutive cycles: the load returns the new data.
//  resp_valid is never asserted in CLEAR.
// CONFIGURATION
//  DM_TRACE_EN defined:
//   every committed store prints "%d@%h: *%h <= %h" ($time, pc, word-aligned addr, merged word);
//   every errored request prints "%d@%h: DM ERR mis=%b rng=%b addr=%h".
//  DM_TRACE_EN undefined: no $display; no functional difference.
// STRUCTURE
//  dm_pkg: CTL_BYTE=2'd0, CTL_HALF=2'd1, CTL_WORD=2'd2, CTL_ILL=2'd3; FSM state encoding ST_CLEAR, ST_IDLE.
//  Sub-module dm_load_align (combinational): word, addr[1:0], ctl, sext -> extended rd.
//  Top holds the FSM, clear counter, byte-enable RAM array and response registers.
// TESTING (bench with ADDR_W=4, DEPTH=16)
//  clr 1 cycle then low -> ready=0 for 16 cycles, 1 on 16th edge; load 0x3C reads 0.
//  Store word 0xDEADBEEF @0x8, then lb sext @0xB -> rd=0xFFFFFFDE.
//   Then lbu @0x9 -> rd=0x000000BE; lh @0xA sext -> rd=0xFFFFDEAD.
//  sb wd=0x12 @0x5 over word 0 -> load word @0x4 = 0x00001200.
//   Then sh wd=0xABCD @0x6 -> 0xABCD1200.
//  lw @0x6 -> err_mis=1, rd=0. sw @0x40 -> err_range=1, mem unchanged.
//   ctl=3 -> err_mis=1.
//  clr at sweep cycle 7 -> sweep restarts; ready after 16 further cycles.
//   req held during CLEAR gives no resp_valid.
//  Back-to-back: sw 0x1 @0x0 then lw @0x0 next cycle -> rd=0x1; one resp_valid per request.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the banked data memory.
//   - ctl encodings for access width (byte / half / word / illegal)
//   - sweep/idle FSM state encoding
//   - helpers for alignment checking and byte-enable generation
package dm_pkg;

    localparam logic [1:0] CTL_BYTE = 2'd0;
    localparam logic [1:0] CTL_HALF = 2'd1;
    localparam logic [1:0] CTL_WORD = 2'd2;
    localparam logic [1:0] CTL_ILL  = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Half accesses need an even address, word accesses a 4-byte aligned one;
    // the illegal width code is always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] ctl, input logic [1:0] lane);
        case (ctl)
            CTL_BYTE: return 1'b0;
            CTL_HALF: return lane[0];
            CTL_WORD: return lane != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] ctl, input logic [1:0] lane);
        case (ctl)
            CTL_BYTE: return 4'b0001 << lane;
            CTL_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            CTL_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load data extraction: picks the addressed byte/half out of a 32-bit word
// and sign- or zero-extends it.
// Ports:
//   word  in  32  full memory word
//   lane  in  2   byte offset addr[1:0]
//   ctl   in  2   access width (dm_pkg CTL_*)
//   sext  in  1   1 = sign-extend, 0 = zero-extend (ignored for word)
//   rd    out 32  extended load result (0 for the illegal width code)
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  ctl,
    input  logic        sext,
    output logic [31:0] rd
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every signal written in always_comb gets a default on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sel_byte = 8'(word >> {lane, 3'b000});
        sel_half = lane[1] ? word[31:16] : word[15:0];
        rd       = '0;
        case (ctl)
            CTL_BYTE: rd = {{24{sext & sel_byte[7]}}, sel_byte};
            CTL_HALF: rd = {{16{sext & sel_half[15]}}, sel_half};
            CTL_WORD: rd = word;
            default:  rd = '0;
        endcase
    end

endmodule

// File: rtl/dm_banked.sv
// Banked single-port data memory for the MEM stage.
// Byte-enable stores, sign/zero-extending loads, registered 1-cycle response
// with misalignment and out-of-range flags. After clr the array is swept to
// zero one word per cycle; ready stays low until the sweep completes.
// Optional trace: define DM_TRACE_EN to print committed stores and errors.
// Ports:
//   clk        in   1   clock, all logic on posedge
//   clr        in   1   synchronous active-high reset, restarts the sweep
//   req        in   1   request, accepted when req & ready
//   we         in   1   1 = store, 0 = load
//   ctl        in   2   0 byte, 1 half, 2 word, 3 illegal
//   sext       in   1   load sign-extend select
//   addr       in   32  byte address
//   wd         in   32  right-justified store data
//   pc         in   32  issuing PC, trace only
//   ready      out  1   memory idle, request can be accepted
//   resp_valid out  1   pulse one cycle after an accepted request
//   rd         out  32  load result, 0 for stores and errors
//   err_mis    out  1   misaligned address or illegal ctl
//   err_range  out  1   address outside the memory window
module dm_banked
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  ctl,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rd,
    output logic        err_mis,
    output logic        err_range
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rd_q, rd_d;
    logic        err_mis_q, err_mis_d;
    logic        err_range_q, err_range_d;

    logic              accept;
    logic              mis;
    logic              rng;
    logic              do_store;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic [31:0]       ld_word;
    logic [31:0]       ld_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) state_d = ST_IDLE;  // last word being zeroed
            end
            default: ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = (state_q == ST_IDLE);
    end

    // ---------------- request decode ----------------
    always_comb begin
        accept   = req & ready & ~clr;  // a request in the reset cycle is dropped
        word_idx = addr[ADDR_W+1:2];
        mis      = is_misaligned(ctl, addr[1:0]);
        rng      = addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
        do_store = accept & we & ~mis & ~rng;
        st_be    = byte_en(ctl, addr[1:0]);
        case (ctl)
            CTL_BYTE: st_data = {4{wd[7:0]}};
            CTL_HALF: st_data = {2{wd[15:0]}};
            default:  st_data = wd;
        endcase
    end

    // ---------------- single write port: sweep or store ----------------
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_be    = st_be;
        mem_wdata = st_data;
        if (state_q == ST_CLEAR && !clr) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end else if (do_store) begin
            mem_we    = 1'b1;
        end
    end

    // NOTE: the array has no reset branch; it is zeroed by the sweep instead,
    // which keeps it mappable onto RAM resources.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem_q[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    // A store lands at its accept edge, so a load accepted on the following
    // edge already reads the merged word here.
    assign ld_word = mem_q[word_idx];

    dm_load_align u_align (
        .word (ld_word),
        .lane (addr[1:0]),
        .ctl  (ctl),
        .sext (sext),
        .rd   (ld_data)
    );

    // ---------------- response registers ----------------
    always_comb begin
        resp_valid_d = accept;
        rd_d         = rd_q;
        err_mis_d    = err_mis_q;
        err_range_d  = err_range_q;
        if (accept) begin
            err_mis_d   = mis;
            err_range_d = rng;
            rd_d        = (we | mis | rng) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            resp_valid_q <= 1'b0;
            rd_q         <= '0;
            err_mis_q    <= 1'b0;
            err_range_q  <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            rd_q         <= rd_d;
            err_mis_q    <= err_mis_d;
            err_range_q  <= err_range_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign rd         = rd_q;
    assign err_mis    = err_mis_q;
    assign err_range  = err_range_q;

`ifdef DM_TRACE_EN
    logic [31:0] merged;

    always_comb begin
        merged = ld_word;
        for (int k = 0; k < 4; k++) begin
            if (st_be[k]) merged[8*k +: 8] = st_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (do_store)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
        if (accept && (mis || rng))
            $display("%d@%h: DM ERR mis=%b rng=%b addr=%h", $time, pc, mis, rng, addr);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_banked.sv
// Directed self-checking bench for dm_banked with ADDR_W=4 (16 words).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge after the accepting rising edge.
module tb_dm_banked;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        req;
    logic        we;
    logic [1:0]  ctl;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        ready;
    logic        resp_valid;
    logic [31:0] rd;
    logic        err_mis;
    logic        err_range;

    int n_checks = 0;
    int n_errors = 0;
    int edges;
    int pulses;

    dm_banked #(
        .ADDR_W    (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .we         (we),
        .ctl        (ctl),
        .sext       (sext),
        .addr       (addr),
        .wd         (wd),
        .pc         (pc),
        .ready      (ready),
        .resp_valid (resp_valid),
        .rd         (rd),
        .err_mis    (err_mis),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request, then check the registered response it produces.
    task automatic access(input string tag, input logic w, input logic [1:0] c,
                          input logic s, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_mis,
                          input logic exp_rng);
        @(negedge clk);
        req  = 1'b1;
        we   = w;
        ctl  = c;
        sext = s;
        addr = a;
        wd   = d;
        pc   = pc + 32'd4;
        @(negedge clk);
        req = 1'b0;
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".rd"},    rd, exp_rd);
        check({tag, ".mis"},   32'(err_mis), 32'(exp_mis));
        check({tag, ".rng"},   32'(err_range), 32'(exp_rng));
    endtask

    // Counts rising edges until ready rises (bounded) and resp_valid pulses seen.
    task automatic wait_ready(output int n_edges, output int n_pulses);
        n_edges  = -1;
        n_pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) n_pulses++;
            if (ready) begin
                n_edges = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset cycle with a request present: it must be dropped.
        clr  = 1'b1;
        req  = 1'b1;
        we   = 1'b0;
        ctl  = CTL_WORD;
        sext = 1'b0;
        addr = 32'h3C;
        wd   = '0;
        pc   = 32'h0040_0000;
        @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.rd",    rd, 32'd0);
        check("rst.mis",   32'(err_mis), 32'd0);
        check("rst.rng",   32'(err_range), 32'd0);

        // Sweep with req held high: ready on the 16th edge, no responses.
        clr = 1'b0;
        wait_ready(edges, pulses);
        req = 1'b0;
        check("sweep.len",     32'(edges), 32'd16);
        check("sweep.no_resp", 32'(pulses), 32'd0);

        access("lw_3c",  1'b0, CTL_WORD, 1'b0, 32'h3C, 32'h0,        32'h0000_0000, 1'b0, 1'b0);
        access("sw_8",   1'b1, CTL_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 1'b0);
        access("lb_b",   1'b0, CTL_BYTE, 1'b1, 32'h0B, 32'h0,        32'hFFFF_FFDE, 1'b0, 1'b0);

        // Outputs hold after the response pulse.
        @(negedge clk);
        check("hold.valid", 32'(resp_valid), 32'd0);
        check("hold.rd",    rd, 32'hFFFF_FFDE);

        access("lbu_9",  1'b0, CTL_BYTE, 1'b0, 32'h09, 32'h0,        32'h0000_00BE, 1'b0, 1'b0);
        access("lh_a",   1'b0, CTL_HALF, 1'b1, 32'h0A, 32'h0,        32'hFFFF_DEAD, 1'b0, 1'b0);
        access("lhu_8",  1'b0, CTL_HALF, 1'b0, 32'h08, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0);
        access("sb_5",   1'b1, CTL_BYTE, 1'b0, 32'h05, 32'h12,       32'h0000_0000, 1'b0, 1'b0);
        access("lw_4",   1'b0, CTL_WORD, 1'b0, 32'h04, 32'h0,        32'h0000_1200, 1'b0, 1'b0);
        access("lb_5",   1'b0, CTL_BYTE, 1'b1, 32'h05, 32'h0,        32'h0000_0012, 1'b0, 1'b0);
        access("sh_6",   1'b1, CTL_HALF, 1'b0, 32'h06, 32'hABCD,     32'h0000_0000, 1'b0, 1'b0);
        access("lw_4b",  1'b0, CTL_WORD, 1'b0, 32'h04, 32'h0,        32'hABCD_1200, 1'b0, 1'b0);

        // Error cases.
        access("lw_6",   1'b0, CTL_WORD, 1'b0, 32'h06, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
        access("sw_40",  1'b1, CTL_WORD, 1'b0, 32'h40, 32'h55,       32'h0000_0000, 1'b0, 1'b1);
        access("lw_0",   1'b0, CTL_WORD, 1'b0, 32'h00, 32'h0,        32'h0000_0000, 1'b0, 1'b0);
        access("ctl3",   1'b0, CTL_ILL,  1'b0, 32'h00, 32'h0,        32'h0000_0000, 1'b1, 1'b0);
        access("both",   1'b0, CTL_WORD, 1'b0, 32'h41, 32'h0,        32'h0000_0000, 1'b1, 1'b1);

        // Back-to-back store then load of the same word.
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b1;
        ctl  = CTL_WORD;
        sext = 1'b0;
        addr = 32'h0;
        wd   = 32'h1;
        @(negedge clk);
        check("b2b.sw.valid", 32'(resp_valid), 32'd1);
        check("b2b.sw.rd",    rd, 32'd0);
        we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("b2b.lw.valid", 32'(resp_valid), 32'd1);
        check("b2b.lw.rd",    rd, 32'h1);
        @(negedge clk);
        check("b2b.idle",     32'(resp_valid), 32'd0);

        // Clear restarted at sweep cycle 7, with a request held throughout.
        @(negedge clk);
        clr  = 1'b1;
        req  = 1'b1;
        we   = 1'b0;
        ctl  = CTL_WORD;
        addr = 32'h8;
        @(negedge clk);
        clr = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("mid.ready", 32'(ready), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_ready(edges, pulses);
        req = 1'b0;
        check("restart.len",     32'(edges), 32'd16);
        check("restart.no_resp", 32'(pulses), 32'd0);

        access("lw_8_clr", 1'b0, CTL_WORD, 1'b0, 32'h08, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
        access("lw_0_clr", 1'b0, CTL_WORD, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
